snd_i2s_tx: RTL and testbench

Serial audio output stage of the sound IP. It pulls one mixed stereo sample per audio frame from the mixer's FIFO-style output (first-word-fall-through: data valid while VALID is high, RD pops) and serializes it to an external DAC in standard I2S format. It generates BCLK and LRCK from the system clock, inserts silence on underrun or mute, and counts underruns for software.

---
 rtl/snd_i2s_tx.sv | 61 ++++++
 tb/tb_snd_i2s_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/snd_i2s_tx.sv
// snd_i2s_tx: I2S serializer pulling one stereo sample per frame from a FWFT FIFO
// Ports:
//   CLK, RST             system clock, synchronous active-high reset
//   FIFO_VALID/DOUT/RD   FWFT sample input ([31:16] right, [15:0] left), RD pops
//   MUTE                 send zeros while still draining the FIFO
//   I2S_BCLK/LRCK/SDATA  serial output, data changes on BCLK falling edge
//   UNDERRUN_CNT         saturating count of fetches that found the FIFO empty
module snd_i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FIFO_VALID,
  input  logic [31:0] FIFO_DOUT,
  output logic        FIFO_RD,
  input  logic        MUTE,
  output logic        I2S_BCLK,
  output logic        I2S_LRCK,
  output logic        I2S_SDATA,
  output logic [15:0] UNDERRUN_CNT
);
  localparam int DW = $clog2(BCLK_DIV);
  logic [DW-1:0] div;
  logic [4:0]    slot, slot_n;
  logic [31:0]   sr, nxt;
  logic [15:0]   ucnt;
  logic          wrap, fe, fetch;
  assign wrap = div == DW'(BCLK_DIV - 1);
  assign fe = wrap & I2S_BCLK;
  assign slot_n = slot + 5'd1;
  // fetch on the falling edge that enters slot 31, so NXT is ready for slot 0
  assign fetch = fe & (slot_n == 5'd31);
  assign FIFO_RD = fetch & FIFO_VALID & ~RST;
  assign UNDERRUN_CNT = ucnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      div       <= '0;
      slot      <= 5'd31;
      sr        <= '0;
      nxt       <= '0;
      ucnt      <= '0;
      I2S_BCLK  <= 1'b0;
      I2S_LRCK  <= 1'b0;
      I2S_SDATA <= 1'b0;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) I2S_BCLK <= ~I2S_BCLK;
      if (fe) begin
        slot      <= slot_n;
        I2S_LRCK  <= slot_n[4];
        I2S_SDATA <= sr[31];
        sr        <= (slot_n == 5'd0) ? nxt : sr << 1;
      end
      if (fetch) begin
        // left word goes first on the wire, so swap halves into the shifter order
        nxt <= (FIFO_VALID && !MUTE) ? {FIFO_DOUT[15:0], FIFO_DOUT[31:16]} : '0;
        if (!FIFO_VALID && ucnt != 16'hFFFF) ucnt <= ucnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_snd_i2s_tx.sv
// tb_snd_i2s_tx: directed self-checking bench for snd_i2s_tx with an I2S receiver model
module tb_snd_i2s_tx;
  localparam int D  = 2;
  localparam int FR = 64 * D;
  localparam int FP = 64 * D - 1;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FIFO_VALID = 1'b1;
  logic [31:0] FIFO_DOUT = 32'h8001_A5C3;
  logic        FIFO_RD;
  logic        MUTE = 1'b0;
  logic        I2S_BCLK, I2S_LRCK, I2S_SDATA;
  logic [15:0] UNDERRUN_CNT;
  int n_cmp = 0;
  int n_bad = 0;
  int clk_cnt = 0;
  int rd_cnt = 0;
  int rd_at = 0;
  int base = 0;
  logic [31:0] sh = '0;
  logic [15:0] left_w = '0;
  logic        plr = 1'b0;
  logic [15:0] dec_l [32];
  logic [15:0] dec_r [32];
  int dec_cnt = 0;
  logic [7:0] pat;
  snd_i2s_tx #(.BCLK_DIV(D)) dut (
    .CLK(CLK), .RST(RST), .FIFO_VALID(FIFO_VALID), .FIFO_DOUT(FIFO_DOUT),
    .FIFO_RD(FIFO_RD), .MUTE(MUTE), .I2S_BCLK(I2S_BCLK), .I2S_LRCK(I2S_LRCK),
    .I2S_SDATA(I2S_SDATA), .UNDERRUN_CNT(UNDERRUN_CNT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    clk_cnt <= clk_cnt + 1;
    if (FIFO_RD) begin
      rd_cnt <= rd_cnt + 1;
      rd_at  <= clk_cnt;
    end
  end
  // receiver: LRCK rise closes the left word, LRCK fall closes the right word
  always @(posedge I2S_BCLK) begin
    sh = {sh[30:0], I2S_SDATA};
    if (I2S_LRCK && !plr) left_w = sh[15:0];
    if (!I2S_LRCK && plr && dec_cnt < 32) begin
      dec_l[dec_cnt] = left_w;
      dec_r[dec_cnt] = sh[15:0];
      dec_cnt++;
    end
    plr = I2S_LRCK;
  end
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_rd(input int target);
    for (int i = 0; i < 3 * FR && rd_cnt < target; i++) tick(1);
    chk("pop_timeout", 32'(rd_cnt >= target), 32'd1);
  endtask
  task automatic release_rst();
    RST = 1'b0;
    base = clk_cnt;
  endtask
  initial begin
    tick(5);
    chk("rst_bclk", 32'(I2S_BCLK), 32'd0);
    chk("rst_lrck", 32'(I2S_LRCK), 32'd0);
    chk("rst_sdata", 32'(I2S_SDATA), 32'd0);
    chk("rst_rd", 32'(FIFO_RD), 32'd0);
    chk("rst_ucnt", 32'(UNDERRUN_CNT), 32'd0);
    release_rst();
    for (int i = 0; i < 8; i++) begin
      tick(1);
      pat[i] = I2S_BCLK;
    end
    chk("bclk_pattern", 32'(pat), 32'h66);
    wait_rd(1);
    chk("first_pop_offset", 32'(rd_at - base), 32'(FP));
    wait_rd(2);
    chk("second_pop_offset", 32'(rd_at - base), 32'(FP + FR));
    FIFO_VALID = 1'b0;
    tick(3 * FR);
    chk("underrun_cnt3", 32'(UNDERRUN_CNT), 32'd3);
    chk("no_pop_in_gap", 32'(rd_cnt), 32'd2);
    FIFO_VALID = 1'b1;
    FIFO_DOUT = 32'h1234_5678;
    wait_rd(3);
    chk("pop_after_gap", 32'(rd_at - base), 32'(FP + 5 * FR));
    MUTE = 1'b1;
    FIFO_DOUT = 32'h7FFF_7FFF;
    wait_rd(5);
    chk("muted_pops_offset", 32'(rd_at - base), 32'(FP + 7 * FR));
    MUTE = 1'b0;
    wait_rd(6);
    FIFO_VALID = 1'b0;
    force dut.ucnt = 16'hFFFE;
    tick(1);
    release dut.ucnt;
    tick(1);
    chk("ucnt_preset", 32'(UNDERRUN_CNT), 32'hFFFE);
    tick(FR - 2);
    chk("ucnt_reach_max", 32'(UNDERRUN_CNT), 32'hFFFF);
    tick(3 * FR);
    chk("ucnt_saturate", 32'(UNDERRUN_CNT), 32'hFFFF);
    FIFO_VALID = 1'b1;
    chk("decode_count", 32'(dec_cnt >= 10), 32'd1);
    chk("dec0_left_silent", 32'(dec_l[0]), 32'h0);
    chk("dec0_right_silent", 32'(dec_r[0]), 32'h0);
    chk("dec1_left", 32'(dec_l[1]), 32'hA5C3);
    chk("dec1_right", 32'(dec_r[1]), 32'h8001);
    chk("dec2_left", 32'(dec_l[2]), 32'hA5C3);
    chk("dec2_right", 32'(dec_r[2]), 32'h8001);
    for (int k = 3; k <= 5; k++) begin
      chk($sformatf("underrun_left%0d", k), 32'(dec_l[k]), 32'h0);
      chk($sformatf("underrun_right%0d", k), 32'(dec_r[k]), 32'h0);
    end
    chk("dec6_left", 32'(dec_l[6]), 32'h5678);
    chk("dec6_right", 32'(dec_r[6]), 32'h1234);
    for (int k = 7; k <= 8; k++) begin
      chk($sformatf("mute_left%0d", k), 32'(dec_l[k]), 32'h0);
      chk($sformatf("mute_right%0d", k), 32'(dec_r[k]), 32'h0);
    end
    chk("unmute_left", 32'(dec_l[9]), 32'h7FFF);
    chk("unmute_right", 32'(dec_r[9]), 32'h7FFF);
    wait_rd(7);
    tick(86);
    chk("slot20_lrck", 32'(I2S_LRCK), 32'd1);
    RST = 1'b1;
    tick(1);
    chk("abort_bclk", 32'(I2S_BCLK), 32'd0);
    chk("abort_lrck", 32'(I2S_LRCK), 32'd0);
    chk("abort_sdata", 32'(I2S_SDATA), 32'd0);
    chk("abort_rd", 32'(FIFO_RD), 32'd0);
    chk("abort_ucnt", 32'(UNDERRUN_CNT), 32'd0);
    tick(3);
    chk("no_pop_in_reset", 32'(rd_cnt), 32'd7);
    release_rst();
    wait_rd(8);
    chk("pop_after_abort", 32'(rd_at - base), 32'(FP));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
